fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request/acknowledge handshake, and holds the IF/ID pipeline register that feeds decode and the hazard-detection unit. It obeys the hazard unit's `pc_write` / `IF_ID_write` stall outputs and the branch/jump redirect from ID. A one-entry skid buffer absorbs instructions returned by a variable-latency memory while decode is stalled.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types and constants for the fetch stage and IF/ID register.
package fetch_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    BUF  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  // Instruction word paired with the PC+4 of the address it came from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc4;
  } fetch_pkt_t;

  // Sequential next PC; wraps modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with write enable and bubble insertion.
// A bubble wins over a held register so that a redirect always flushes.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              bubble_i,
  input  fetch_pkt_t        pkt_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              valid_o
);

  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;

  // Reset / bubble / load / hold of the pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (we_i) begin
      inst_q  <= pkt_i.inst;
      pc4_q   <= pkt_i.pc4;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request/ack handshake, one-entry skid buffer
// and redirect handling with discard of an in-flight request.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write_i,
  input  logic              IF_ID_write_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] IF_ID_inst_o,
  output logic [ADDR_W-1:0] IF_ID_pc4_o,
  output logic              IF_ID_valid_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  fetch_pkt_t        buf_q, buf_d;

  logic              adv;
  logic [ADDR_W-1:0] pc_next;
  logic              ifid_we;
  logic              ifid_bubble;
  fetch_pkt_t        ifid_pkt;

  assign adv     = pc_write_i & IF_ID_write_i;
  assign pc_next = pc_plus4(pc_q);

  // State, PC, discard address and skid buffer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_q       <= buf_d;
    end
  end

  // Next-state, PC update and IF/ID control; redirect outranks stall
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    buf_d       = buf_q;
    ifid_we     = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pkt    = '{inst: imem_data_i, pc4: pc_next};

    unique case (state_q)
      REQ: begin
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          ifid_bubble = 1'b1;
          if (!imem_ack_i) begin
            // Request still in flight: keep presenting it until its ack
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_next;
          if (adv) begin
            ifid_we = 1'b1;
          end else begin
            buf_d   = '{inst: imem_data_i, pc4: pc_next};
            state_d = BUF;
          end
        end else if (adv) begin
          ifid_bubble = 1'b1;
        end
      end

      BUF: begin
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          ifid_bubble = 1'b1;
          state_d     = REQ;
        end else if (adv) begin
          ifid_we  = 1'b1;
          ifid_pkt = buf_q;
          state_d  = REQ;
        end
      end

      KILL: begin
        if (redirect_i) begin
          pc_d        = redirect_pc_i;
          ifid_bubble = 1'b1;
        end else if (adv) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ack_i) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Request is live in REQ and KILL; KILL keeps the abandoned address on the bus
  assign imem_req_o  = ~rst_i & (state_q != BUF);
  assign imem_addr_o = (state_q == KILL) ? kill_addr_q : pc_q;

  if_id_reg u_if_id_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (ifid_we),
    .bubble_i (ifid_bubble),
    .pkt_i    (ifid_pkt),
    .inst_o   (IF_ID_inst_o),
    .pc4_o    (IF_ID_pc4_o),
    .valid_o  (IF_ID_valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized traffic
// against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_write_i    (pc_write),
    .IF_ID_write_i (if_id_write),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .IF_ID_inst_o  (if_inst),
    .IF_ID_pc4_o   (if_pc4),
    .IF_ID_valid_o (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        adv;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } pkt_t;

  // Reference model: fetch pointer, pending skid entry, discard bookkeeping
  logic [31:0] m_pc;
  logic [31:0] m_kill_pc;
  bit          m_discard;
  pkt_t        m_skid[$];
  bit          m_rst;
  logic [31:0] e_inst, e_pc4;
  bit          e_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                     input logic adv, input logic ack, input logic [31:0] data,
                     input logic ereq, input logic [31:0] eaddr, input logic ev,
                     input logic [31:0] einst, input logic [31:0] epc4);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.adv = adv; v.ack = ack; v.data = data;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_inst = einst; v.e_pc4 = epc4;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic adv, input logic ack, input logic [31:0] data);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    pc_write    = adv;
    if_id_write = adv;
    imem_ack    = ack;
    imem_data   = data;
  endtask

  task automatic model_step(input bit r, input bit rd, input logic [31:0] rpc,
                            input bit adv, input bit ack, input logic [31:0] data);
    pkt_t p;
    logic [31:0] nxt;
    if (r) begin
      m_pc = RST_PC; m_discard = 0; m_skid.delete();
      e_inst = 0; e_pc4 = 0; e_valid = 0;
    end else if (rd) begin
      e_inst = 0; e_valid = 0;
      if (m_discard) m_discard = !ack;
      else if (m_skid.size() == 0 && !ack) begin
        m_discard = 1; m_kill_pc = m_pc;
      end
      m_skid.delete();
      m_pc = rpc;
    end else if (m_discard) begin
      if (adv) begin e_inst = 0; e_valid = 0; end
      if (ack) m_discard = 0;
    end else if (m_skid.size() != 0) begin
      if (adv) begin
        p = m_skid.pop_front();
        e_inst = p.inst; e_pc4 = p.pc4; e_valid = 1;
      end
    end else if (ack) begin
      nxt = m_pc + 32'd4;
      if (adv) begin
        e_inst = data; e_pc4 = nxt; e_valid = 1;
      end else begin
        p.inst = data; p.pc4 = nxt;
        m_skid.push_back(p);
      end
      m_pc = nxt;
    end else if (adv) begin
      e_inst = 0; e_valid = 0;
    end
    m_rst = r;
  endtask

  initial begin
    bit          r_rst, r_redir, r_adv, r_ack, m_req, mem_busy;
    logic [31:0] r_rpc, r_data, m_addr;
    int          mem_wait;

    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // rst redir rpc adv ack data | req addr valid inst pc4
    add(1, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'h0,        1, 32'h4,        1, 32'h0,   32'h4);
    add(0, 0, 32'h0,         1, 1, 32'h4,        1, 32'h8,        1, 32'h4,   32'h8);
    add(0, 0, 32'h0,         0, 1, 32'h8,        0, 32'hC,        1, 32'h4,   32'h8);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'hC,        1, 32'h4,   32'h8);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'hC,        1, 32'h8,   32'hC);
    add(0, 0, 32'h0,         1, 1, 32'hC,        1, 32'h10,       1, 32'hC,   32'h10);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h10,       0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h10,       0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'h10,       1, 32'h14,       1, 32'h10,  32'h14);
    add(0, 0, 32'h0,         1, 1, 32'h14,       1, 32'h18,       1, 32'h14,  32'h18);
    add(0, 0, 32'h0,         1, 1, 32'h18,       1, 32'h1C,       1, 32'h18,  32'h1C);
    add(0, 0, 32'h0,         1, 1, 32'h1C,       1, 32'h20,       1, 32'h1C,  32'h20);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h20,       0, 32'h0,   32'h0);
    add(0, 1, 32'h100,       1, 0, 32'h0,        1, 32'h20,       0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h20,       0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'hDEAD,     1, 32'h100,      0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'h100,      1, 32'h104,      1, 32'h100, 32'h104);
    add(0, 0, 32'h0,         0, 1, 32'h104,      0, 32'h108,      1, 32'h100, 32'h104);
    add(0, 1, 32'h200,       0, 0, 32'h0,        1, 32'h200,      0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'h200,      1, 32'h204,      1, 32'h200, 32'h204);
    add(0, 0, 32'h0,         1, 0, 32'h0,        1, 32'h204,      0, 32'h0,   32'h0);
    add(0, 1, 32'h300,       1, 0, 32'h0,        1, 32'h204,      0, 32'h0,   32'h0);
    add(0, 1, 32'h400,       1, 0, 32'h0,        1, 32'h204,      0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'hBEEF,     1, 32'h400,      0, 32'h0,   32'h0);
    add(0, 1, 32'h500,       1, 0, 32'h0,        1, 32'h400,      0, 32'h0,   32'h0);
    add(1, 0, 32'h0,         1, 0, 32'h0,        0, RST_PC,       0, 32'h0,   32'h0);
    add(0, 0, 32'h0,         1, 1, 32'h77,       1, 32'h4,        1, 32'h77,  32'h4);
    add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h4,        1, 32'hFFFF_FFFC, 0, 32'h0,  32'h0);
    add(0, 0, 32'h0,         1, 1, 32'hABC,      1, 32'h0,        1, 32'hABC, 32'h0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].adv, vecs[i].ack, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d addr", i),  imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d inst", i),  if_inst, vecs[i].e_inst);
      if (vecs[i].e_valid || vecs[i].rst)
        chk($sformatf("vec%0d pc4", i), if_pc4, vecs[i].e_pc4);
    end

    // Randomized traffic with variable-latency memory
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    model_step(1, 0, 32'h0, 1, 0, 32'h0);
    mem_busy = 0;
    mem_wait = 0;
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      chk("rnd req",   {31'b0, imem_req}, {31'b0, !m_rst && m_skid.size() == 0});
      chk("rnd addr",  imem_addr, m_discard ? m_kill_pc : m_pc);
      chk("rnd valid", {31'b0, if_valid}, {31'b0, e_valid});
      chk("rnd inst",  if_inst, e_inst);
      if (e_valid) chk("rnd pc4", if_pc4, e_pc4);

      r_rst   = ($urandom_range(0, 99) == 0);
      r_redir = ($urandom_range(0, 99) < 6);
      r_rpc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      r_adv   = ($urandom_range(0, 3) != 0);
      m_req   = !r_rst && m_skid.size() == 0;
      m_addr  = m_discard ? m_kill_pc : m_pc;
      r_ack   = 0;
      r_data  = $urandom;
      if (r_rst) begin
        mem_busy = 0;
      end else if (m_req) begin
        if (!mem_busy) begin
          mem_busy = 1;
          mem_wait = $urandom_range(0, 3);
        end
        if (mem_wait == 0) begin
          r_ack    = 1;
          mem_busy = 0;
          r_data   = r_data ^ m_addr;
        end else begin
          mem_wait--;
        end
      end
      drive(r_rst, r_redir, r_rpc, r_adv, r_ack, r_data);
      model_step(r_rst, r_redir, r_rpc, r_adv, r_ack, r_data);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
